boot_loader: RTL and testbench
==============================

# boot_loader

Boot copy sequencer directly downstream of the 16-word boot ROM. After reset release (or on `start`), it reads every ROM word in order, writes each into main RAM at `BASE + index`, and keeps a running 16-bit checksum. It holds the CPU in reset (`cpu_hold`) until the copy completes, then releases it and flags `done`.

## Interface
- `WORDS`, 16, number of ROM words copied (1..16)
- `RAM_AW`, 12, main RAM address width
- `BASE`, 0, RAM destination address of ROM word 0
- `AUTO_START`, 1, 1 = begin copy on first clock after reset release
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle pulse; starts a copy from IDLE or DONE, ignored while busy
- `rom_cs`  out  1  ROM chip select
- `rom_we`  out  1  ROM write enable, constant 0
- `rom_addr`  out  4  ROM word address
- `rom_data`  in  16  ROM read data
- `ram_cs`  out  1  RAM chip select
- `ram_we`  out  1  RAM write enable
- `ram_addr`  out  RAM_AW  RAM word address
- `ram_wdata`  out  16  RAM write data
- `ram_ready`  in  1  RAM accepted the write this cycle
- `cpu_hold`  out  1  holds CPU in reset while 1
- `busy`  out  1  copy in progress
- `done`  out  1  copy completed; sticky until next start or reset
- `checksum`  out  16  mod-2^16 sum of the words copied so far

## Operation
- States: IDLE, READ, CAPT, WRITE, DONE.
- Reset (async, `rst_n`=0):
  - State IDLE; index 0; checksum 0; `done`=0; `busy`=0; `cpu_hold`=1.
  - `rom_cs`=0, `ram_cs`=0, `ram_we`=0; `rom_addr`, `ram_addr`, `ram_wdata` all 0.
- IDLE -> READ: on the first clock when `AUTO_START`=1, otherwise on `start`. Clears index and checksum and sets `busy`.
- READ: drives `rom_cs`=1 and `rom_addr`=index. -> CAPT.
- CAPT: `rom_cs` stays 1. Registers `rom_data` into the write-data register and adds it to the checksum (16-bit, carry discarded). -> WRITE.
- WRITE: drives `ram_cs`=`ram_we`=1, `ram_addr`=`BASE`+index (truncated to `RAM_AW`), `ram_wdata`=captured word.
  - Holds until the cycle `ram_ready`=1.
  - If index = `WORDS`-1: -> DONE. Otherwise index+1 and -> READ.
- DONE: `busy`=0, `done`=1, `cpu_hold`=0.
  - `start` clears `done`, sets `cpu_hold`=1, and re-enters READ with index and checksum cleared.
- `rom_we` is always 0. `rom_cs` and `ram_cs` are never both 1.
- Index does not wrap. The last address read is `WORDS`-1.

## Timing
- Per word: READ 1 cycle + CAPT 1 cycle + WRITE (1 + RAM wait cycles).
- With `ram_ready` tied to 1: 3 cycles per word. For `WORDS`=16 and `AUTO_START`=1, DONE is entered on clock edge 48 after reset release, and `cpu_hold` falls in the same cycle.
- All outputs are registered. Nothing combinational runs from `ram_ready` or `rom_data` to any output.
- `ram_ready` sampled outside WRITE is ignored.
- `checksum` updates at the end of CAPT and is final when `done` rises.
- `start` asserted while `busy`=1: ignored, no restart, no error.
- `start` in the same cycle DONE is entered: ignored, because it is sampled only while in IDLE or DONE.
- `rst_n` low mid-copy: immediate return to reset values. A RAM write in flight is abandoned, and a partial copy is not resumed. Copying restarts from word 0 after release.
- Stalling: `ram_ready` held low keeps WRITE with address and data stable indefinitely.

## Test plan
- Auto copy, ROM loaded with {F200,4000,F800,1007,F400,3010,4000,0007, 8×0000}, `ram_ready`=1:
  - RAM[0..15] equals the ROM image.
  - `checksum`=9E1E, `done`=1, and `cpu_hold` falls 48 cycles after reset release.
- RAM stall: `ram_ready` low for 5 cycles on word 3:
  - `ram_addr`=3 and `ram_wdata`=1007 stay stable through the stall.
  - Total copy time is 53 cycles. Final contents are unchanged.
- `BASE`=0x100, `WORDS`=8:
  - Writes land at 0x100..0x107 and nothing beyond.
  - `rom_addr` never exceeds 7. `checksum`=9E1E.
- Reset mid-copy: `rst_n` pulsed low during word 5 WRITE:
  - All outputs return to reset values asynchronously.
  - After release the copy restarts at `rom_addr`=0 and completes with `checksum`=9E1E.
- `start` handling, `AUTO_START`=0:
  - No activity until `start`.
  - A second `start` while busy is ignored.
  - `start` in DONE repeats the copy, and `done` drops for the whole run.
- Protocol checks throughout: `rom_we`=0 at all times, `rom_cs` and `ram_cs` never both high, and `ram_we` only with `ram_cs`.

Source files
------------

// File: rtl/boot_loader_if.sv
// boot_loader_if: boot ROM read port and main RAM write port driven by the boot copy sequencer.
interface boot_loader_if #(
  parameter int RAM_AW = 12
);
  logic              rom_cs;
  logic              rom_we;
  logic [3:0]        rom_addr;
  logic [15:0]       rom_data;
  logic              ram_cs;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [15:0]       ram_wdata;
  logic              ram_ready;

  modport master (
    output rom_cs, rom_we, rom_addr,
    input  rom_data,
    output ram_cs, ram_we, ram_addr, ram_wdata,
    input  ram_ready
  );

  modport slave (
    input  rom_cs, rom_we, rom_addr,
    output rom_data,
    input  ram_cs, ram_we, ram_addr, ram_wdata,
    output ram_ready
  );
endinterface

// File: rtl/boot_loader.sv
// boot_loader: copies WORDS boot ROM words into main RAM at BASE, keeps a
// 16-bit running checksum and holds the CPU in reset until the copy is done.
// Every output is a register; the next values are formed in one comb block.
module boot_loader #(
  parameter int WORDS      = 16,
  parameter int RAM_AW     = 12,
  parameter int BASE       = 0,
  parameter int AUTO_START = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  boot_loader_if.master bus,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic [15:0]   checksum
);
  localparam logic [3:0]        LAST   = 4'(WORDS - 1);
  localparam logic [RAM_AW-1:0] BASE_A = RAM_AW'(BASE);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPT, S_WRITE, S_DONE} state_t;

  state_t            state, state_n;
  logic [3:0]        idx, idx_n;
  logic [15:0]       sum_n, wdata_n;
  logic              hold_n, busy_n, done_n;
  logic              rom_cs_n, ram_cs_n;
  logic [3:0]        rom_addr_n;
  logic [RAM_AW-1:0] ram_addr_n;

  // The ROM is only ever read.
  assign bus.rom_we = 1'b0;

  // State, index and all registered outputs; reset returns everything to idle values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      idx           <= '0;
      checksum      <= '0;
      cpu_hold      <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      bus.rom_cs    <= 1'b0;
      bus.rom_addr  <= '0;
      bus.ram_cs    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      checksum      <= sum_n;
      cpu_hold      <= hold_n;
      busy          <= busy_n;
      done          <= done_n;
      bus.rom_cs    <= rom_cs_n;
      bus.rom_addr  <= rom_addr_n;
      bus.ram_cs    <= ram_cs_n;
      bus.ram_we    <= ram_cs_n;
      bus.ram_addr  <= ram_addr_n;
      bus.ram_wdata <= wdata_n;
    end
  end

  // Next state and next register values; bus strobes are decoded from the next state.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    sum_n   = checksum;
    wdata_n = bus.ram_wdata;
    hold_n  = cpu_hold;
    busy_n  = busy;
    done_n  = done;
    case (state)
      S_IDLE: begin
        if (AUTO_START != 0 || start) begin
          state_n = S_READ;
          idx_n   = '0;
          sum_n   = '0;
          busy_n  = 1'b1;
        end
      end
      S_READ: state_n = S_CAPT;
      S_CAPT: begin
        wdata_n = bus.rom_data;
        sum_n   = checksum + bus.rom_data;
        state_n = S_WRITE;
      end
      S_WRITE: begin
        if (bus.ram_ready) begin
          if (idx == LAST) begin
            state_n = S_DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            hold_n  = 1'b0;
          end else begin
            idx_n   = idx + 4'd1;
            state_n = S_READ;
          end
        end
      end
      S_DONE: begin
        if (start) begin
          state_n = S_READ;
          idx_n   = '0;
          sum_n   = '0;
          done_n  = 1'b0;
          hold_n  = 1'b1;
          busy_n  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    rom_cs_n   = (state_n == S_READ) || (state_n == S_CAPT);
    ram_cs_n   = (state_n == S_WRITE);
    rom_addr_n = (state_n == S_READ) ? idx_n : bus.rom_addr;
    ram_addr_n = (state_n == S_WRITE) ? BASE_A + RAM_AW'(idx_n) : bus.ram_addr;
  end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: three boot_loader configurations (auto 16 words at 0,
// auto 8 words at 0x100, manual start) with ROM/RAM models and random stalls.
`timescale 1ns/1ps
module tb_boot_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic rst_n0 = 1'b0, rst_n1 = 1'b0, rst_n2 = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic hold0, hold1, hold2, busy0, busy1, busy2, done0, done1, done2;
  logic [15:0] sum0, sum1, sum2;

  boot_loader_if #(.RAM_AW(12)) bus0 ();
  boot_loader_if #(.RAM_AW(12)) bus1 ();
  boot_loader_if #(.RAM_AW(12)) bus2 ();

  boot_loader #(.WORDS(16), .RAM_AW(12), .BASE(0), .AUTO_START(1)) u0 (
    .clk(clk), .rst_n(rst_n0), .start(start0), .bus(bus0),
    .cpu_hold(hold0), .busy(busy0), .done(done0), .checksum(sum0));
  boot_loader #(.WORDS(8), .RAM_AW(12), .BASE('h100), .AUTO_START(1)) u1 (
    .clk(clk), .rst_n(rst_n1), .start(start1), .bus(bus1),
    .cpu_hold(hold1), .busy(busy1), .done(done1), .checksum(sum1));
  boot_loader #(.WORDS(16), .RAM_AW(12), .BASE(0), .AUTO_START(0)) u2 (
    .clk(clk), .rst_n(rst_n2), .start(start2), .bus(bus2),
    .cpu_hold(hold2), .busy(busy2), .done(done2), .checksum(sum2));

  // ROM models: combinational read of the addressed word
  logic [15:0] rom0 [16];
  logic [15:0] rom1 [16];
  logic [15:0] rom2 [16];
  assign bus0.rom_data = rom0[bus0.rom_addr];
  assign bus1.rom_data = rom1[bus1.rom_addr];
  assign bus2.rom_data = rom2[bus2.rom_addr];

  // RAM models: each accepted write stores data plus the run tag it belongs to
  logic [15:0] ram0 [4096];
  logic [15:0] ram1 [4096];
  logic [15:0] ram2 [4096];
  int tag0 [4096];
  int tag1 [4096];
  int tag2 [4096];
  int gen0 = 0, gen1 = 0, gen2 = 0;
  int wcnt0 = 0, wcnt1 = 0, wcnt2 = 0, badw1 = 0;

  always @(posedge clk) begin
    if (bus0.ram_cs === 1'b1 && bus0.ram_we === 1'b1 && bus0.ram_ready === 1'b1) begin
      ram0[bus0.ram_addr] <= bus0.ram_wdata;
      tag0[bus0.ram_addr] <= gen0;
      wcnt0 <= wcnt0 + 1;
    end
    if (bus1.ram_cs === 1'b1 && bus1.ram_we === 1'b1 && bus1.ram_ready === 1'b1) begin
      ram1[bus1.ram_addr] <= bus1.ram_wdata;
      tag1[bus1.ram_addr] <= gen1;
      wcnt1 <= wcnt1 + 1;
      if (bus1.ram_addr < 12'h100 || bus1.ram_addr > 12'h107) badw1 <= badw1 + 1;
    end
    if (bus2.ram_cs === 1'b1 && bus2.ram_we === 1'b1 && bus2.ram_ready === 1'b1) begin
      ram2[bus2.ram_addr] <= bus2.ram_wdata;
      tag2[bus2.ram_addr] <= gen2;
      wcnt2 <= wcnt2 + 1;
    end
  end

  // ram_ready responders: mode0 1 = five stall cycles on address 3, 2 = random
  int mode0 = 0, stall_base0 = 0, stalls0 = 0;
  int rnd1 = 0, stalls1 = 0;
  assign bus2.ram_ready = 1'b1;

  always @(negedge clk) begin
    if (bus0.ram_cs === 1'b1 &&
        ((mode0 == 1 && bus0.ram_addr == 12'd3 && stalls0 - stall_base0 < 5) ||
         (mode0 == 2 && $urandom_range(0, 2) == 0))) begin
      bus0.ram_ready = 1'b0;
      stalls0++;
    end else begin
      bus0.ram_ready = (mode0 == 2 && bus0.ram_cs !== 1'b1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (rnd1 != 0 && bus1.ram_cs === 1'b1 && $urandom_range(0, 2) == 0) begin
      bus1.ram_ready = 1'b0;
      stalls1++;
    end else begin
      bus1.ram_ready = 1'b1;
    end
  end

  // Bus protocol monitor and activity trackers
  int prot_bad = 0;
  int act2 = 0;
  logic [3:0] maxrom1 = 4'd0;
  always @(negedge clk) begin
    if (bus0.rom_we !== 1'b0 || (bus0.rom_cs === 1'b1 && bus0.ram_cs === 1'b1) ||
        (bus0.ram_we === 1'b1 && bus0.ram_cs !== 1'b1)) prot_bad++;
    if (bus1.rom_we !== 1'b0 || (bus1.rom_cs === 1'b1 && bus1.ram_cs === 1'b1) ||
        (bus1.ram_we === 1'b1 && bus1.ram_cs !== 1'b1)) prot_bad++;
    if (bus2.rom_we !== 1'b0 || (bus2.rom_cs === 1'b1 && bus2.ram_cs === 1'b1) ||
        (bus2.ram_we === 1'b1 && bus2.ram_cs !== 1'b1)) prot_bad++;
    if (bus1.rom_cs === 1'b1 && bus1.rom_addr > maxrom1) maxrom1 = bus1.rom_addr;
    if (bus2.rom_cs === 1'b1 || bus2.ram_cs === 1'b1) act2++;
  end

  // Reference: mod-2^16 sum of the first n image words
  function automatic logic [15:0] model_sum(input logic [15:0] img [16], input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(img[i]);
    return 16'(s % 65536);
  endfunction

  function automatic void load_fixed(output logic [15:0] img [16]);
    img = '{16'hF200, 16'h4000, 16'hF800, 16'h1007, 16'hF400, 16'h3010, 16'h4000, 16'h0007,
            16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
  endfunction

  // Waits for cpu_hold of u0 to fall; edge 0 is the first clock after reset release
  task automatic wait_hold0(output int edges);
    edges = -1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (hold0 === 1'b0) begin
        edges = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if ({hold0, busy0, done0, bus0.rom_cs, bus0.ram_cs, bus0.ram_we} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_ctrl: hold/busy/done/rom_cs/ram_cs/ram_we=%b required 100000",
               {hold0, busy0, done0, bus0.rom_cs, bus0.ram_cs, bus0.ram_we});
    end
    n_chk++;
    if (sum0 !== 16'h0000) begin
      n_fail++; $display("FAIL reset_checksum: got %h required 0000", sum0);
    end
    n_chk++;
    if ({bus0.rom_addr, bus0.ram_addr, bus0.ram_wdata} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_bus: rom_addr %h ram_addr %h ram_wdata %h required all 0",
               bus0.rom_addr, bus0.ram_addr, bus0.ram_wdata);
    end
    n_chk++;
    if ({hold1, hold2} !== 2'b11) begin
      n_fail++; $display("FAIL reset_hold_others: got %b required 11", {hold1, hold2});
    end
  endtask

  task automatic test_auto_copy();
    int edges, w0;
    load_fixed(rom0);
    gen0++; mode0 = 0; rst_n0 = 1'b0;
    @(negedge clk); w0 = wcnt0; rst_n0 = 1'b1;
    wait_hold0(edges);
    n_chk++;
    if (edges !== 48) begin
      n_fail++; $display("FAIL auto_latency: cpu_hold fell on edge %0d required 48", edges);
    end
    n_chk++;
    if (sum0 !== 16'h9E1E || sum0 !== model_sum(rom0, 16)) begin
      n_fail++; $display("FAIL auto_checksum: got %h required 9e1e", sum0);
    end
    n_chk++;
    if ({done0, busy0} !== 2'b10) begin
      n_fail++; $display("FAIL auto_flags: done/busy=%b required 10", {done0, busy0});
    end
    n_chk++;
    if (wcnt0 - w0 !== 16) begin
      n_fail++; $display("FAIL auto_write_count: got %0d required 16", wcnt0 - w0);
    end
    for (int i = 0; i < 16; i++) begin
      n_chk++;
      if (ram0[i] !== rom0[i] || tag0[i] != gen0) begin
        n_fail++; $display("FAIL auto_ram[%0d]: got %h required %h", i, ram0[i], rom0[i]);
      end
    end
  endtask

  task automatic test_ram_stall();
    int edges, w0, seen, bad;
    load_fixed(rom0);
    gen0++; mode0 = 1; rst_n0 = 1'b0;
    @(negedge clk); w0 = wcnt0; stall_base0 = stalls0; rst_n0 = 1'b1;
    edges = -1; seen = 0; bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (bus0.ram_cs === 1'b1 && bus0.ram_addr == 12'd3) begin
        seen++;
        if (bus0.ram_wdata !== 16'h1007) bad++;
      end
      if (hold0 === 1'b0) begin
        edges = i;
        break;
      end
    end
    mode0 = 0;
    n_chk++;
    if (seen !== 6 || bad !== 0) begin
      n_fail++;
      $display("FAIL stall_stable: addr 3 held %0d cycles with %0d bad data, required 6 and 0", seen, bad);
    end
    n_chk++;
    if (edges !== 53) begin
      n_fail++; $display("FAIL stall_latency: cpu_hold fell on edge %0d required 53", edges);
    end
    n_chk++;
    if (sum0 !== 16'h9E1E || wcnt0 - w0 !== 16) begin
      n_fail++; $display("FAIL stall_result: checksum %h writes %0d required 9e1e and 16", sum0, wcnt0 - w0);
    end
    for (int i = 0; i < 16; i++) begin
      n_chk++;
      if (ram0[i] !== rom0[i] || tag0[i] != gen0) begin
        n_fail++; $display("FAIL stall_ram[%0d]: got %h required %h", i, ram0[i], rom0[i]);
      end
    end
  endtask

  task automatic test_random_stall();
    int edges, s0;
    logic [15:0] exp_sum;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) rom0[i] = 16'($urandom);
      exp_sum = model_sum(rom0, 16);
      gen0++; mode0 = 2; rst_n0 = 1'b0;
      @(negedge clk); s0 = stalls0; rst_n0 = 1'b1;
      wait_hold0(edges);
      mode0 = 0;
      n_chk++;
      if (edges !== 48 + (stalls0 - s0)) begin
        n_fail++;
        $display("FAIL rand_latency: run %0d done on edge %0d required %0d", r, edges, 48 + (stalls0 - s0));
      end
      n_chk++;
      if (sum0 !== exp_sum) begin
        n_fail++; $display("FAIL rand_checksum: run %0d got %h required %h", r, sum0, exp_sum);
      end
      for (int i = 0; i < 16; i++) begin
        n_chk++;
        if (ram0[i] !== rom0[i] || tag0[i] != gen0) begin
          n_fail++; $display("FAIL rand_ram[%0d]: got %h required %h", i, ram0[i], rom0[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midcopy();
    int edges, w0, first, found;
    load_fixed(rom0);
    gen0++; mode0 = 0; rst_n0 = 1'b0;
    @(negedge clk); rst_n0 = 1'b1;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (bus0.ram_cs === 1'b1 && bus0.ram_addr == 12'd5) begin
        found = 1;
        break;
      end
    end
    n_chk++;
    if (found !== 1) begin
      n_fail++; $display("FAIL midrst_reach: word 5 write seen %0d required 1", found);
    end
    #2 rst_n0 = 1'b0;
    #1;
    n_chk++;
    if ({hold0, busy0, done0, bus0.rom_cs, bus0.ram_cs, bus0.ram_we} !== 6'b100000) begin
      n_fail++;
      $display("FAIL midrst_ctrl: hold/busy/done/rom_cs/ram_cs/ram_we=%b required 100000",
               {hold0, busy0, done0, bus0.rom_cs, bus0.ram_cs, bus0.ram_we});
    end
    n_chk++;
    if (sum0 !== 16'h0000 || {bus0.rom_addr, bus0.ram_addr, bus0.ram_wdata} !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_data: checksum %h rom_addr %h ram_addr %h wdata %h required all 0",
               sum0, bus0.rom_addr, bus0.ram_addr, bus0.ram_wdata);
    end
    @(negedge clk); gen0++; w0 = wcnt0; rst_n0 = 1'b1;
    edges = -1; first = -1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (first < 0 && bus0.rom_cs === 1'b1) first = int'(bus0.rom_addr);
      if (hold0 === 1'b0) begin
        edges = i;
        break;
      end
    end
    n_chk++;
    if (first !== 0) begin
      n_fail++; $display("FAIL midrst_restart: first rom_addr %0d required 0", first);
    end
    n_chk++;
    if (edges !== 48 || sum0 !== 16'h9E1E || wcnt0 - w0 !== 16) begin
      n_fail++;
      $display("FAIL midrst_finish: edge %0d checksum %h writes %0d required 48 9e1e 16",
               edges, sum0, wcnt0 - w0);
    end
    for (int i = 0; i < 16; i++) begin
      n_chk++;
      if (ram0[i] !== rom0[i] || tag0[i] != gen0) begin
        n_fail++; $display("FAIL midrst_ram[%0d]: got %h required %h", i, ram0[i], rom0[i]);
      end
    end
  endtask

  task automatic test_base_words();
    int edges, w0, b0, s0;
    load_fixed(rom1);
    gen1++; rnd1 = 1;
    @(negedge clk); w0 = wcnt1; b0 = badw1; s0 = stalls1; rst_n1 = 1'b1;
    edges = -1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (hold1 === 1'b0) begin
        edges = i;
        break;
      end
    end
    rnd1 = 0;
    n_chk++;
    if (edges !== 24 + (stalls1 - s0)) begin
      n_fail++; $display("FAIL base_latency: done on edge %0d required %0d", edges, 24 + (stalls1 - s0));
    end
    n_chk++;
    if (sum1 !== 16'h9E1E || sum1 !== model_sum(rom1, 8)) begin
      n_fail++; $display("FAIL base_checksum: got %h required 9e1e", sum1);
    end
    n_chk++;
    if (wcnt1 - w0 !== 8 || badw1 - b0 !== 0) begin
      n_fail++;
      $display("FAIL base_writes: %0d writes, %0d outside 0x100..0x107, required 8 and 0",
               wcnt1 - w0, badw1 - b0);
    end
    n_chk++;
    if (maxrom1 > 4'd7) begin
      n_fail++; $display("FAIL base_rom_addr: max rom_addr %0d required at most 7", maxrom1);
    end
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (ram1['h100 + i] !== rom1[i] || tag1['h100 + i] != gen1) begin
        n_fail++; $display("FAIL base_ram[%0h]: got %h required %h", 'h100 + i, ram1['h100 + i], rom1[i]);
      end
    end
  endtask

  task automatic test_start();
    int edges, w0, a0, bad;
    logic [15:0] exp_sum;
    for (int i = 0; i < 16; i++) rom2[i] = 16'($urandom);
    exp_sum = model_sum(rom2, 16);
    gen2++;
    @(negedge clk); a0 = act2; rst_n2 = 1'b1;
    repeat (12) @(negedge clk);
    n_chk++;
    if (act2 - a0 !== 0 || {hold2, busy2, done2} !== 3'b100) begin
      n_fail++;
      $display("FAIL start_idle: %0d active cycles, hold/busy/done=%b, required 0 and 100",
               act2 - a0, {hold2, busy2, done2});
    end
    // first run, with a second start pulse while busy
    w0 = wcnt2; start2 = 1'b1; edges = -1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (i == 0 || i == 11) start2 = 1'b0;
      if (i == 10) start2 = 1'b1;
      if (hold2 === 1'b0) begin
        edges = i;
        break;
      end
    end
    n_chk++;
    if (edges !== 48 || wcnt2 - w0 !== 16) begin
      n_fail++; $display("FAIL start_busy_ignored: done edge %0d writes %0d required 48 and 16", edges, wcnt2 - w0);
    end
    n_chk++;
    if (sum2 !== exp_sum || done2 !== 1'b1) begin
      n_fail++; $display("FAIL start_run1: checksum %h done %b required %h and 1", sum2, done2, exp_sum);
    end
    // repeat from DONE
    repeat (3) @(negedge clk);
    n_chk++;
    if (done2 !== 1'b1) begin
      n_fail++; $display("FAIL start_sticky: done %b required 1", done2);
    end
    gen2++; w0 = wcnt2; start2 = 1'b1; edges = -1; bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (i == 0) start2 = 1'b0;
      if (hold2 === 1'b0) begin
        edges = i;
        break;
      end
      if (done2 !== 1'b0 || busy2 !== 1'b1) bad++;
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL start_done_low: %0d cycles with done high or busy low, required 0", bad);
    end
    n_chk++;
    if (edges !== 48 || sum2 !== exp_sum || wcnt2 - w0 !== 16) begin
      n_fail++;
      $display("FAIL start_run2: edge %0d checksum %h writes %0d required 48 %h 16",
               edges, sum2, wcnt2 - w0, exp_sum);
    end
    for (int i = 0; i < 16; i++) begin
      n_chk++;
      if (ram2[i] !== rom2[i] || tag2[i] != gen2) begin
        n_fail++; $display("FAIL start_ram[%0d]: got %h required %h", i, ram2[i], rom2[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_auto_copy();
    test_ram_stall();
    test_random_stall();
    test_reset_midcopy();
    test_base_words();
    test_start();
    n_chk++;
    if (prot_bad !== 0) begin
      n_fail++; $display("FAIL protocol: %0d violating cycles required 0", prot_bad);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
